frogger_game_ctrl: RTL and testbench

Top-level game sequencer for the Frogger design. It owns the run/idle/end state, the lives counter and the score. It consumes collision, frog-position and tile-under-frog information, then drives the game-active gate, the frog respawn pulse and the score fed to the 7-segment driver. All timed phases are counted in video frames, derived from VSync.

---
 rtl/frogger_pkg.sv | 41 ++++
 rtl/frogger_game_ctrl_if.sv | 44 ++++
 rtl/frame_tick_gen.sv | 51 +++++
 rtl/frogger_game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frogger_pkg.sv
// -----------------------------------------------------------------------------
// frogger_pkg
// Shared definitions for the Frogger game sequencer:
//   - game state encodings (3-bit, as exported on o_State)
//   - tile bitmap codes
//   - shared field widths (tile coordinate, score, lives)
//   - saturating score increment helper
// -----------------------------------------------------------------------------
package frogger_pkg;

    localparam int TILE_W  = 6;
    localparam int SCORE_W = 7;
    localparam int LIVES_W = 2;
    localparam int STATE_W = 3;
    localparam int BMP_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_CLEANUP   = 3'd2,
        ST_P1_WINS   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    typedef enum logic [BMP_W-1:0] {
        TILE_WALL  = 4'd0,
        TILE_ROAD  = 4'd1,
        TILE_WATER = 4'd2,
        TILE_SAFE  = 4'd3,
        TILE_LILY  = 4'd4
    } tile_e;

    // Score increment that sticks at the ceiling instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_sat_inc(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] ceiling
    );
        return (score >= ceiling) ? ceiling : score + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// frogger_game_ctrl_if
// Bundle of the signals exchanged between the game sequencer and the rest of
// the Frogger design (sync counter, frog controller, collision logic, display).
//   i_VSync        VSync from sync counter, falling edge = frame tick
//   i_Game_Start   start button level (debounced upstream)
//   i_Collided     frog/car collision flag
//   i_Frogger_Y    frog tile row
//   i_Bitmap_Data  bitmap code of the tile under the frog
//   o_State        sequencer state encoding
//   o_Game_Active  high only while RUNNING
//   o_Respawn      one-cycle frog reload pulse
//   o_Lives        remaining lives
//   o_Score        crossings completed
//   o_Flash        end-screen blink
// Modports: slave = the sequencer (consumes i_*, drives o_*),
//           master = the surrounding game logic (drives i_*, consumes o_*).
// -----------------------------------------------------------------------------
interface frogger_game_ctrl_if;
    import frogger_pkg::*;

    logic               i_VSync;
    logic               i_Game_Start;
    logic               i_Collided;
    logic [TILE_W-1:0]  i_Frogger_Y;
    logic [BMP_W-1:0]   i_Bitmap_Data;
    logic [STATE_W-1:0] o_State;
    logic               o_Game_Active;
    logic               o_Respawn;
    logic [LIVES_W-1:0] o_Lives;
    logic [SCORE_W-1:0] o_Score;
    logic               o_Flash;

    modport master (
        output i_VSync, i_Game_Start, i_Collided, i_Frogger_Y, i_Bitmap_Data,
        input  o_State, o_Game_Active, o_Respawn, o_Lives, o_Score, o_Flash
    );

    modport slave (
        input  i_VSync, i_Game_Start, i_Collided, i_Frogger_Y, i_Bitmap_Data,
        output o_State, o_Game_Active, o_Respawn, o_Lives, o_Score, o_Flash
    );

endinterface

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// VSync falling-edge detector plus a frame counter.
//   i_Clk    clock
//   i_Rst    synchronous active-high reset (clears edge register and count)
//   i_VSync  VSync level
//   i_Clr    holds the counter at zero while high
//   o_Tick   one-cycle pulse: VSync was high last cycle and is low now
//   o_Last   count is at c_TERM-1, so the next tick completes the period;
//            the counter wraps to zero on that tick
// -----------------------------------------------------------------------------
module frame_tick_gen #(
    parameter int c_TERM = 60
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_VSync,
    input  logic i_Clr,
    output logic o_Tick,
    output logic o_Last
);

    localparam int CNT_W = (c_TERM > 1) ? $clog2(c_TERM) : 1;

    logic             vsync_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_Tick = vsync_q & ~i_VSync;
    assign o_Last = (count_q == CNT_W'(c_TERM - 1));

    always_comb begin
        count_d = count_q;
        if (i_Clr) begin
            count_d = '0;
        end else if (o_Tick) begin
            count_d = o_Last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            vsync_q <= 1'b0;
            count_q <= '0;
        end else begin
            vsync_q <= i_VSync;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frogger_game_ctrl.sv
// -----------------------------------------------------------------------------
// frogger_game_ctrl
// Top-level game sequencer: IDLE / RUNNING / CLEANUP / P1_WINS / GAME_OVER.
// Owns lives and score, gates the game with o_Game_Active, requests frog
// respawns and blinks o_Flash on the end screens. Timed phases count video
// frames (VSync falling edges).
//   i_Clk  clock
//   i_Rst  synchronous active-high reset
//   bus    frogger_game_ctrl_if.slave: game inputs in, sequencer outputs out
// All outputs come straight from flops and change on the transition edge.
// -----------------------------------------------------------------------------
module frogger_game_ctrl
    import frogger_pkg::*;
#(
    parameter int c_START_LIVES  = 3,
    parameter int c_WIN_SCORE    = 5,
    parameter int c_SCORE_MAX    = 99,
    parameter int c_HOLD_FRAMES  = 60,
    parameter int c_FLASH_FRAMES = 15,
    parameter int c_GOAL_ROW     = 0,
    parameter int c_TILE_WATER   = 2,
    parameter int c_TILE_LILY    = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    frogger_game_ctrl_if.slave  bus
);

    localparam logic [LIVES_W-1:0] START_LIVES_V = LIVES_W'(c_START_LIVES);
    localparam logic [SCORE_W-1:0] WIN_SCORE_V   = SCORE_W'(c_WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX_V   = SCORE_W'(c_SCORE_MAX);
    localparam logic [TILE_W-1:0]  GOAL_ROW_V    = TILE_W'(c_GOAL_ROW);
    localparam logic [BMP_W-1:0]   TILE_WATER_V  = BMP_W'(c_TILE_WATER);
    localparam logic [BMP_W-1:0]   TILE_LILY_V   = BMP_W'(c_TILE_LILY);

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               arm_q, arm_d;
    logic               game_active_q, game_active_d;
    logic               respawn_q, respawn_d;
    logic               flash_q, flash_d;
    logic               start_q;

    logic               start_edge;
    logic               respawn_req;
    logic               in_end_q;
    logic               death_evt;
    logic               goal_evt;
    logic [SCORE_W-1:0] score_inc;

    logic hold_tick, hold_last;
    logic flash_tick, flash_last;

    assign start_edge = ~start_q & bus.i_Game_Start;
    assign in_end_q   = (state_q == ST_P1_WINS) || (state_q == ST_GAME_OVER);
    assign death_evt  = bus.i_Collided || (bus.i_Bitmap_Data == TILE_WATER_V);
    assign goal_evt   = (bus.i_Frogger_Y == GOAL_ROW_V) &&
                        (bus.i_Bitmap_Data == TILE_LILY_V);
    assign score_inc  = score_sat_inc(score_q, SCORE_MAX_V);

    // Hold timer: counts only while in CLEANUP, so it is zero on entry.
    // Its tick output also serves as the frame tick for arming.
    frame_tick_gen #(.c_TERM(c_HOLD_FRAMES)) u_hold_timer (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_VSync (bus.i_VSync),
        .i_Clr   (state_q != ST_CLEANUP),
        .o_Tick  (hold_tick),
        .o_Last  (hold_last)
    );

    // Flash timer: counts only on the end screens.
    frame_tick_gen #(.c_TERM(c_FLASH_FRAMES)) u_flash_timer (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_VSync (bus.i_VSync),
        .i_Clr   (!in_end_q),
        .o_Tick  (flash_tick),
        .o_Last  (flash_last)
    );

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q       <= ST_IDLE;
            lives_q       <= START_LIVES_V;
            score_q       <= '0;
            arm_q         <= 1'b0;
            start_q       <= 1'b0;
            game_active_q <= 1'b0;
            respawn_q     <= 1'b0;
            flash_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            arm_q         <= arm_d;
            start_q       <= bus.i_Game_Start;
            game_active_q <= game_active_d;
            respawn_q     <= respawn_d;
            flash_q       <= flash_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        arm_d       = 1'b0;
        respawn_req = 1'b0;

        case (state_q)
            ST_IDLE, ST_P1_WINS, ST_GAME_OVER: begin
                if (start_edge) begin
                    state_d     = ST_RUNNING;
                    lives_d     = START_LIVES_V;
                    score_d     = '0;
                    respawn_req = 1'b1;
                end
            end

            ST_RUNNING: begin
                // Arm stays clear until the first frame after entry so that
                // collision/tile data left over from before the respawn is
                // not acted on.
                arm_d = arm_q | hold_tick;
                if (arm_q && death_evt) begin
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = ST_CLEANUP;
                    end
                end else if (arm_q && goal_evt) begin
                    score_d = score_inc;
                    state_d = (score_inc >= WIN_SCORE_V) ? ST_P1_WINS : ST_CLEANUP;
                end
            end

            ST_CLEANUP: begin
                if (hold_tick && hold_last) begin
                    state_d     = ST_RUNNING;
                    respawn_req = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic (registered from the next state)
    always_comb begin
        game_active_d = (state_d == ST_RUNNING);
        respawn_d     = respawn_req;
        flash_d       = 1'b0;
        if ((state_d == ST_P1_WINS) || (state_d == ST_GAME_OVER)) begin
            if (!in_end_q) begin
                flash_d = 1'b1;
            end else if (flash_tick && flash_last) begin
                flash_d = ~flash_q;
            end else begin
                flash_d = flash_q;
            end
        end
    end

    assign bus.o_State       = state_q;
    assign bus.o_Game_Active = game_active_q;
    assign bus.o_Respawn     = respawn_q;
    assign bus.o_Lives       = lives_q;
    assign bus.o_Score       = score_q;
    assign bus.o_Flash       = flash_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frogger_game_ctrl
// Bench for the Frogger game sequencer: a reset/start vector table, directed
// multi-cycle sequences (hold timing, arming, goals, deaths, flash period,
// reset mid-CLEANUP) and a randomized run, with a game-rules reference model
// checked every clock.
// -----------------------------------------------------------------------------
module tb_frogger_game_ctrl;

    localparam int START_LIVES = 3;
    localparam int WIN_SCORE   = 5;
    localparam int SCORE_MAX   = 99;
    localparam int HOLD        = 60;
    localparam int FLASH       = 15;
    localparam int VS_PERIOD   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frogger_game_ctrl_if bus();

    frogger_game_ctrl #(
        .c_START_LIVES  (START_LIVES),
        .c_WIN_SCORE    (WIN_SCORE),
        .c_SCORE_MAX    (SCORE_MAX),
        .c_HOLD_FRAMES  (HOLD),
        .c_FLASH_FRAMES (FLASH),
        .c_GOAL_ROW     (0),
        .c_TILE_WATER   (2),
        .c_TILE_LILY    (4)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    int n_vec   = 0;
    int n_fail  = 0;
    int n_print = 0;
    int cyc     = 0;
    bit vs_en   = 1'b0;
    bit was_tick;

    // Reference model: game rules with plain integers.
    // States: 0 idle, 1 running, 2 cleanup, 3 win, 4 game over.
    int m_state, m_lives, m_score, m_hold, m_fl_cnt;
    bit m_armed, m_active, m_resp, m_flash, m_pvs, m_pstart;

    function automatic void model_clock(input bit r, input bit vs, input bit st,
                                        input bit col, input int y, input int bm);
        bit tick, sedge, death, goal;
        int ns;
        tick  = m_pvs && !vs;
        sedge = !m_pstart && st;
        m_resp = 1'b0;
        if (r) begin
            m_state = 0; m_lives = START_LIVES; m_score = 0; m_hold = 0;
            m_fl_cnt = 0; m_armed = 0; m_active = 0; m_flash = 0;
            m_pvs = 0; m_pstart = 0;
            return;
        end
        m_pvs = vs;
        m_pstart = st;
        death = col || (bm == 2);
        goal  = (y == 0) && (bm == 4);
        ns = m_state;
        if (m_state == 0 || m_state >= 3) begin
            if (sedge) begin
                ns = 1; m_lives = START_LIVES; m_score = 0; m_resp = 1;
            end else if (m_state >= 3 && tick) begin
                m_fl_cnt++;
                if (m_fl_cnt == FLASH) begin
                    m_fl_cnt = 0;
                    m_flash = !m_flash;
                end
            end
        end else if (m_state == 1) begin
            if (!m_armed) begin
                m_armed = tick;
            end else if (death) begin
                if (m_lives <= 1) begin m_lives = 0; ns = 4; end
                else begin m_lives--; ns = 2; end
            end else if (goal) begin
                m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
                ns = (m_score >= WIN_SCORE) ? 3 : 2;
            end
        end else begin
            if (tick) begin
                m_hold++;
                if (m_hold == HOLD) begin ns = 1; m_resp = 1; end
            end
        end
        if (ns != m_state) begin
            if (ns == 1) m_armed = 0;
            if (ns == 2) m_hold = 0;
            if (ns >= 3) begin m_flash = 1; m_fl_cnt = 0; end
            else m_flash = 0;
        end
        m_state  = ns;
        m_active = (ns == 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)",
                         name, cyc, act, act, exp, exp);
            end
        end
    endtask

    // One clock: update VSync, advance the model, clock the DUT, compare.
    task automatic step();
        int dv, mv;
        if (vs_en) bus.i_VSync = ((cyc % VS_PERIOD) < VS_PERIOD / 2);
        was_tick = !rst && m_pvs && !bus.i_VSync;
        model_clock(rst, bus.i_VSync, bus.i_Game_Start, bus.i_Collided,
                    int'(bus.i_Frogger_Y), int'(bus.i_Bitmap_Data));
        @(posedge clk);
        #1;
        cyc++;
        dv = {bus.o_State, bus.o_Game_Active, bus.o_Respawn, bus.o_Lives,
              bus.o_Score, bus.o_Flash};
        mv = {3'(m_state), m_active, m_resp, 2'(m_lives), 7'(m_score), m_flash};
        check("model{state,act,resp,lives,score,flash}", dv, mv);
    endtask

    task automatic safe_inputs();
        bus.i_Collided = 1'b0;
        bus.i_Frogger_Y = 6'd20;
        bus.i_Bitmap_Data = 4'd3;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!was_tick && n < 4 * VS_PERIOD);
        if (!was_tick) check("wait_tick_timeout", 0, 1);
    endtask

    // Wait for the first frame after entering RUNNING, then one more cycle.
    task automatic arm();
        wait_tick();
        step();
    endtask

    task automatic run_until_respawn(output int ticks);
        int n;
        ticks = 0;
        n = 0;
        do begin
            step();
            if (was_tick) ticks++;
            n++;
        end while (bus.o_Respawn !== 1'b1 && n < (HOLD + 4) * VS_PERIOD);
        check("respawn_seen", int'(bus.o_Respawn === 1'b1), 1);
    endtask

    task automatic kill(input bit water);
        if (water) bus.i_Bitmap_Data = 4'd2;
        else bus.i_Collided = 1'b1;
        step();
        safe_inputs();
    endtask

    typedef struct {
        bit rst, start, col;
        int y, bm;
        int e_state, e_lives, e_score, e_act, e_resp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int t, cnt, prev;
        bus.i_VSync = 1'b1;
        bus.i_Game_Start = 1'b0;
        safe_inputs();

        // rst, start, col, y, bm | state, lives, score, active, respawn
        tbl[0] = '{1, 0, 0, 20, 3, 0, 3, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 20, 3, 0, 3, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 20, 3, 1, 3, 0, 1, 1};
        tbl[3] = '{0, 1, 0, 20, 3, 1, 3, 0, 1, 0};
        tbl[4] = '{0, 1, 1, 20, 3, 1, 3, 0, 1, 0};
        tbl[5] = '{0, 0, 0, 0,  4, 1, 3, 0, 1, 0};
        tbl[6] = '{0, 0, 0, 20, 2, 1, 3, 0, 1, 0};
        tbl[7] = '{1, 0, 0, 20, 3, 0, 3, 0, 0, 0};
        tbl[8] = '{0, 1, 0, 20, 3, 1, 3, 0, 1, 1};

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst;
            bus.i_Game_Start = tbl[i].start;
            bus.i_Collided = tbl[i].col;
            bus.i_Frogger_Y = 6'(tbl[i].y);
            bus.i_Bitmap_Data = 4'(tbl[i].bm);
            step();
            check("tbl_state",   int'(bus.o_State),       tbl[i].e_state);
            check("tbl_lives",   int'(bus.o_Lives),       tbl[i].e_lives);
            check("tbl_score",   int'(bus.o_Score),       tbl[i].e_score);
            check("tbl_active",  int'(bus.o_Game_Active), tbl[i].e_act);
            check("tbl_respawn", int'(bus.o_Respawn),     tbl[i].e_resp);
            check("tbl_flash",   int'(bus.o_Flash),       0);
        end

        // Button held: no further respawn pulses.
        safe_inputs();
        vs_en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.o_Respawn) cnt++;
        end
        check("held_start_respawns", cnt, 0);
        check("held_start_state", int'(bus.o_State), 1);
        bus.i_Game_Start = 1'b0;

        // Collision -> CLEANUP, 60 frames, respawn.
        arm();
        kill(1'b0);
        check("death_lives", int'(bus.o_Lives), 2);
        check("death_state", int'(bus.o_State), 2);
        check("death_active", int'(bus.o_Game_Active), 0);
        run_until_respawn(t);
        check("hold_ticks", t, HOLD);
        check("respawn_state", int'(bus.o_State), 1);

        // Collision held through first frame after respawn is ignored.
        bus.i_Collided = 1'b1;
        wait_tick();
        bus.i_Collided = 1'b0;
        check("masked_lives", int'(bus.o_Lives), 2);
        check("masked_state", int'(bus.o_State), 1);

        // Five goals -> win.
        for (int k = 1; k <= WIN_SCORE; k++) begin
            arm();
            bus.i_Frogger_Y = 6'd0;
            bus.i_Bitmap_Data = 4'd4;
            step();
            safe_inputs();
            check("goal_score", int'(bus.o_Score), k);
            check("goal_state", int'(bus.o_State), (k < WIN_SCORE) ? 2 : 3);
            if (k < WIN_SCORE) run_until_respawn(t);
        end
        check("win_flash_entry", int'(bus.o_Flash), 1);
        prev = int'(bus.o_Flash);
        t = 0;
        cnt = 0;
        for (int n = 0; n < 5 * FLASH * VS_PERIOD && cnt < 3; n++) begin
            step();
            if (was_tick) t++;
            if (int'(bus.o_Flash) != prev) begin
                check("flash_period", t, FLASH);
                prev = int'(bus.o_Flash);
                t = 0;
                cnt++;
            end
        end
        check("flash_toggles", cnt, 3);

        // Restart from win screen.
        bus.i_Game_Start = 1'b1;
        step();
        bus.i_Game_Start = 1'b0;
        check("restart_state", int'(bus.o_State), 1);
        check("restart_lives", int'(bus.o_Lives), 3);
        check("restart_score", int'(bus.o_Score), 0);
        check("restart_resp", int'(bus.o_Respawn), 1);
        check("restart_flash", int'(bus.o_Flash), 0);

        // Death and goal in the same cycle: death wins.
        arm();
        bus.i_Collided = 1'b1;
        bus.i_Frogger_Y = 6'd0;
        bus.i_Bitmap_Data = 4'd4;
        step();
        safe_inputs();
        check("both_lives", int'(bus.o_Lives), 2);
        check("both_score", int'(bus.o_Score), 0);
        check("both_state", int'(bus.o_State), 2);
        run_until_respawn(t);
        arm();
        kill(1'b1);
        check("water_lives", int'(bus.o_Lives), 1);
        run_until_respawn(t);
        arm();
        kill(1'b0);
        check("gameover_lives", int'(bus.o_Lives), 0);
        check("gameover_state", int'(bus.o_State), 4);

        // Restart, then three deaths 3 -> 2 -> 1 -> 0.
        bus.i_Game_Start = 1'b1;
        step();
        bus.i_Game_Start = 1'b0;
        check("go_restart_lives", int'(bus.o_Lives), 3);
        check("go_restart_state", int'(bus.o_State), 1);
        for (int d = 1; d <= 3; d++) begin
            arm();
            kill(d == 2);
            check("three_deaths_lives", int'(bus.o_Lives), 3 - d);
            check("three_deaths_state", int'(bus.o_State), (d < 3) ? 2 : 4);
            if (d < 3) run_until_respawn(t);
        end

        // Reset mid-CLEANUP at frame 30.
        bus.i_Game_Start = 1'b1;
        step();
        bus.i_Game_Start = 1'b0;
        arm();
        bus.i_Frogger_Y = 6'd0;
        bus.i_Bitmap_Data = 4'd4;
        step();
        safe_inputs();
        check("pre_rst_score", int'(bus.o_Score), 1);
        for (int f = 0; f < 30; f++) wait_tick();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_state", int'(bus.o_State), 0);
        check("rst_lives", int'(bus.o_Lives), 3);
        check("rst_score", int'(bus.o_Score), 0);
        check("rst_active", int'(bus.o_Game_Active), 0);
        cnt = int'(bus.o_Respawn);
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.o_Respawn) cnt++;
        end
        check("rst_no_respawn", cnt, 0);
        check("rst_idle_state", int'(bus.o_State), 0);

        // Randomized play against the model.
        for (int i = 0; i < 8000; i++) begin
            rst = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 99) < 2) bus.i_Game_Start = ~bus.i_Game_Start;
            bus.i_Collided = ($urandom_range(0, 39) == 0);
            bus.i_Frogger_Y = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            bus.i_Bitmap_Data = ($urandom_range(0, 99) < 80) ? 4'd3 : 4'($urandom_range(0, 4));
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
